// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: round scheduler for the mole-buster game.
// Sequences IDLE -> COUNTDOWN -> PLAY -> OVER, paces spawn requests,
// raises the level as hits accumulate and keeps score/misses.
// Optional pause support is compiled in when the macro PAUSE_EN is defined.
module mole_round_ctrl #(
  parameter int CW              = 16,
  parameter int COUNTDOWN_TICKS = 3,
  parameter int ROUND_TICKS     = 600,
  parameter int SPAWN_INIT      = 40,
  parameter int SPAWN_MIN       = 8,
  parameter int SPAWN_STEP      = 4,
  parameter int STAY_INIT       = 50,
  parameter int STAY_MIN        = 10,
  parameter int STAY_STEP       = 5,
  parameter int HITS_PER_LEVEL  = 5
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_tick,
  input  logic          i_game_mode,
  input  logic          i_start,
  input  logic          i_hit,
  input  logic          i_miss,
`ifdef PAUSE_EN
  input  logic          i_pause,
  output logic          o_paused,
`endif
  output logic [1:0]    o_state,
  output logic          o_play_en,
  output logic          o_spawn_req,
  output logic [CW-1:0] o_stay_ticks,
  output logic [2:0]    o_level,
  output logic [7:0]    o_score,
  output logic [7:0]    o_misses,
  output logic [CW-1:0] o_time_left,
  output logic          o_game_over
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CD     = 3'd1;
  localparam logic [2:0] ST_PLAY   = 3'd2;
  localparam logic [2:0] ST_OVER   = 3'd3;
`ifdef PAUSE_EN
  localparam logic [2:0] ST_PAUSED = 3'd4;
`endif

  localparam logic [CW-1:0] L_ONE        = CW'(1);
  localparam logic [CW-1:0] L_CD_INIT    = CW'(COUNTDOWN_TICKS);
  localparam logic [CW-1:0] L_ROUND      = CW'(ROUND_TICKS);
  localparam logic [CW-1:0] L_SPAWN_INIT = CW'(SPAWN_INIT);
  localparam logic [CW-1:0] L_SPAWN_MIN  = CW'(SPAWN_MIN);
  localparam logic [CW-1:0] L_SPAWN_STEP = CW'(SPAWN_STEP);
  localparam logic [CW-1:0] L_STAY_INIT  = CW'(STAY_INIT);
  localparam logic [CW-1:0] L_STAY_MIN   = CW'(STAY_MIN);
  localparam logic [CW-1:0] L_STAY_STEP  = CW'(STAY_STEP);
  localparam logic [7:0]    L_HIT_LAST   = 8'(HITS_PER_LEVEL - 1);
  localparam logic [2:0]    L_LEVEL_MAX  = 3'd7;

  // Floored decrement; the compare is done one bit wider so floor+step cannot wrap.
  function automatic logic [CW-1:0] sat_dec(input logic [CW-1:0] value,
                                            input logic [CW-1:0] step,
                                            input logic [CW-1:0] floor_v);
    logic [CW:0] limit;
    limit = {1'b0, floor_v} + {1'b0, step};
    if ({1'b0, value} >= limit) begin
      sat_dec = value - step;
    end else begin
      sat_dec = floor_v;
    end
  endfunction

  // Increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      sat_inc8 = 8'hFF;
    end else begin
      sat_inc8 = value + 8'd1;
    end
  endfunction

  logic [2:0]    r_state;
  logic [1:0]    r_state_o;
  logic          r_play_en;
  logic          r_game_over;
  logic          r_spawn_req;
  logic          r_start_d;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_time_left;
  logic [CW-1:0] r_spawn_cnt;
  logic [CW-1:0] r_period;
  logic [CW-1:0] r_stay;
  logic [2:0]    r_level;
  logic [7:0]    r_score;
  logic [7:0]    r_misses;
  logic [7:0]    r_hit_cnt;

  logic [2:0]    w_state_nxt;
  logic [1:0]    w_state_out;
  logic          w_start_rise;
  logic          w_enter_cd;
  logic          w_enter_play;
  logic          w_play_stay;
  logic          w_play_end;

`ifdef PAUSE_EN
  logic          r_pause_d;
  logic          r_paused;
  logic          w_pause_rise;
  assign w_pause_rise = i_pause & ~r_pause_d;
  // PAUSED is reported on the COUNTDOWN code; o_paused tells them apart.
  assign w_state_out  = (w_state_nxt == ST_PAUSED) ? 2'd1 : w_state_nxt[1:0];
  assign o_paused     = r_paused;
`else
  assign w_state_out  = w_state_nxt[1:0];
`endif

  // A held start must not restart a finished round, so OVER waits for an edge.
  assign w_start_rise = i_start & ~r_start_d;
  assign w_enter_cd   = ((r_state == ST_IDLE) || (r_state == ST_OVER)) && (w_state_nxt == ST_CD);
  assign w_enter_play = (r_state == ST_CD) && (w_state_nxt == ST_PLAY);
  assign w_play_stay  = (r_state == ST_PLAY) && (w_state_nxt == ST_PLAY);
  assign w_play_end   = (r_state == ST_PLAY) && (w_state_nxt == ST_OVER);

  // Next-state selection; game_mode low forces IDLE from anywhere.
  always_comb begin
    w_state_nxt = r_state;
    if (!i_game_mode) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) w_state_nxt = ST_CD;
          else         w_state_nxt = ST_IDLE;
        end
        ST_CD: begin
          if (i_tick && (r_cnt == L_ONE)) w_state_nxt = ST_PLAY;
          else                            w_state_nxt = ST_CD;
        end
        ST_PLAY: begin
`ifdef PAUSE_EN
          if (w_pause_rise)                          w_state_nxt = ST_PAUSED;
          else if (i_tick && (r_time_left == L_ONE)) w_state_nxt = ST_OVER;
          else                                       w_state_nxt = ST_PLAY;
`else
          if (i_tick && (r_time_left == L_ONE)) w_state_nxt = ST_OVER;
          else                                  w_state_nxt = ST_PLAY;
`endif
        end
        ST_OVER: begin
          if (w_start_rise) w_state_nxt = ST_CD;
          else              w_state_nxt = ST_OVER;
        end
`ifdef PAUSE_EN
        ST_PAUSED: begin
          if (w_pause_rise) w_state_nxt = ST_PLAY;
          else              w_state_nxt = ST_PAUSED;
        end
`endif
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register plus the registered state-derived outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_state_o   <= 2'd0;
      r_play_en   <= 1'b0;
      r_game_over <= 1'b0;
      r_start_d   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_state_o   <= w_state_out;
      r_play_en   <= (w_state_nxt == ST_PLAY);
      r_game_over <= (w_state_nxt == ST_OVER);
      r_start_d   <= i_start;
    end
  end

`ifdef PAUSE_EN
  // Pause edge detector and registered paused flag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pause_d <= 1'b0;
      r_paused  <= 1'b0;
    end else begin
      r_pause_d <= i_pause;
      r_paused  <= (w_state_nxt == ST_PAUSED);
    end
  end
`endif

  // Countdown, round timer and spawn pacing; all advance on ticks only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt       <= L_CD_INIT;
      r_time_left <= L_ROUND;
      r_spawn_cnt <= L_ONE;
      r_spawn_req <= 1'b0;
    end else if (!i_game_mode) begin
      r_cnt       <= L_CD_INIT;
      r_time_left <= L_ROUND;
      r_spawn_cnt <= L_ONE;
      r_spawn_req <= 1'b0;
    end else begin
      r_spawn_req <= 1'b0;
      if (w_enter_cd) begin
        r_cnt <= L_CD_INIT;
      end else if (w_enter_play) begin
        // Spawn counter of 1 makes the first PLAY tick spawn a mole.
        r_time_left <= L_ROUND;
        r_spawn_cnt <= L_ONE;
      end else if ((r_state == ST_CD) && i_tick) begin
        r_cnt <= r_cnt - L_ONE;
      end else if (w_play_end) begin
        // Last tick of the round never spawns.
        r_time_left <= r_time_left - L_ONE;
      end else if (w_play_stay && i_tick) begin
        r_time_left <= r_time_left - L_ONE;
        if (r_spawn_cnt <= L_ONE) begin
          r_spawn_req <= 1'b1;
          r_spawn_cnt <= r_period;
        end else begin
          r_spawn_cnt <= r_spawn_cnt - L_ONE;
        end
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // Score, misses and difficulty; hits/misses count only while staying in PLAY.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_score   <= 8'd0;
      r_misses  <= 8'd0;
      r_level   <= 3'd0;
      r_hit_cnt <= 8'd0;
      r_stay    <= L_STAY_INIT;
      r_period  <= L_SPAWN_INIT;
    end else if (!i_game_mode || w_enter_cd) begin
      r_score   <= 8'd0;
      r_misses  <= 8'd0;
      r_level   <= 3'd0;
      r_hit_cnt <= 8'd0;
      r_stay    <= L_STAY_INIT;
      r_period  <= L_SPAWN_INIT;
    end else if (w_play_stay) begin
      if (i_miss) begin
        r_misses <= sat_inc8(r_misses);
      end
      if (i_hit) begin
        r_score <= sat_inc8(r_score);
        if (r_hit_cnt >= L_HIT_LAST) begin
          r_hit_cnt <= 8'd0;
          if (r_level != L_LEVEL_MAX) begin
            // New period is picked up at the next spawn reload.
            r_level  <= r_level + 3'd1;
            r_period <= sat_dec(r_period, L_SPAWN_STEP, L_SPAWN_MIN);
            r_stay   <= sat_dec(r_stay, L_STAY_STEP, L_STAY_MIN);
          end
        end else begin
          r_hit_cnt <= r_hit_cnt + 8'd1;
        end
      end
    end else begin
      r_score <= r_score;
    end
  end

  assign o_state      = r_state_o;
  assign o_play_en    = r_play_en;
  assign o_spawn_req  = r_spawn_req;
  assign o_stay_ticks = r_stay;
  assign o_level      = r_level;
  assign o_score      = r_score;
  assign o_misses     = r_misses;
  assign o_time_left  = r_time_left;
  assign o_game_over  = r_game_over;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Testbench for mole_round_ctrl: directed sequence with randomized tick/hit/miss
// traffic, checked every clock against a round-level reference model.
module tb_mole_round_ctrl;

  localparam int CD_T     = 3;
  localparam int ROUND    = 600;
  localparam int SP_INIT  = 40;
  localparam int SP_MIN   = 8;
  localparam int SP_STEP  = 4;
  localparam int STY_INIT = 50;
  localparam int STY_MIN  = 10;
  localparam int STY_STEP = 5;
  localparam int HPL      = 5;

  localparam int PH_IDLE = 0, PH_CD = 1, PH_PLAY = 2, PH_OVER = 3, PH_PAUSED = 4;

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, gm = 1'b1, start = 1'b0, hit = 1'b0, miss = 1'b0;
  logic [1:0]  o_state;
  logic        o_play_en, o_spawn_req, o_game_over;
  logic [15:0] o_stay_ticks, o_time_left;
  logic [2:0]  o_level;
  logic [7:0]  o_score, o_misses;
`ifdef PAUSE_EN
  logic pause = 1'b0;
  logic o_paused;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: round phase, PLAY tick index, next spawn tick index,
  // total hits/misses in the round; level/period/stay derive from total hits.
  int m_ph, m_cd, m_tl, m_k, m_next, m_hits, m_mis;
  bit m_spawn, m_start_prev, m_pause_prev;

  always #5 clk = ~clk;

  mole_round_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_game_mode(gm), .i_start(start),
    .i_hit(hit), .i_miss(miss),
`ifdef PAUSE_EN
    .i_pause(pause), .o_paused(o_paused),
`endif
    .o_state(o_state), .o_play_en(o_play_en), .o_spawn_req(o_spawn_req),
    .o_stay_ticks(o_stay_ticks), .o_level(o_level), .o_score(o_score),
    .o_misses(o_misses), .o_time_left(o_time_left), .o_game_over(o_game_over)
  );

  function automatic int m_level();
    return (m_hits / HPL > 7) ? 7 : m_hits / HPL;
  endfunction

  function automatic int m_period();
    int p;
    p = SP_INIT - SP_STEP * m_level();
    return (p < SP_MIN) ? SP_MIN : p;
  endfunction

  function automatic int m_stay();
    int s;
    s = STY_INIT - STY_STEP * m_level();
    return (s < STY_MIN) ? STY_MIN : s;
  endfunction

  task automatic model_reset();
    m_ph = PH_IDLE; m_cd = CD_T; m_tl = ROUND; m_k = 0; m_next = 1;
    m_hits = 0; m_mis = 0; m_spawn = 1'b0;
  endtask

  task automatic new_round();
    m_ph = PH_CD; m_cd = CD_T; m_hits = 0; m_mis = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    bit p_rise;
    p_rise = 1'b0;
`ifdef PAUSE_EN
    p_rise = pause && !m_pause_prev;
`endif
    if (rst) begin
      model_reset();
      m_start_prev = 1'b0;
      m_pause_prev = 1'b0;
    end else if (!gm) begin
      model_reset();
      m_start_prev = start;
`ifdef PAUSE_EN
      m_pause_prev = pause;
`endif
    end else begin
      m_spawn = 1'b0;
      case (m_ph)
        PH_IDLE: if (start) new_round();
        PH_CD: begin
          if (tick) begin
            if (m_cd == 1) begin
              m_ph = PH_PLAY; m_k = 0; m_tl = ROUND; m_next = 1;
            end else begin
              m_cd--;
            end
          end
        end
        PH_PLAY: begin
          if (p_rise) begin
            m_ph = PH_PAUSED;
          end else begin
            if (tick) begin
              m_k++;
              m_tl = ROUND - m_k;
              if (m_k == ROUND) begin
                m_ph = PH_OVER;
              end else if (m_k == m_next) begin
                m_spawn = 1'b1;
                m_next = m_k + m_period();
              end
            end
            if (m_ph == PH_PLAY) begin
              if (hit)  m_hits++;
              if (miss) m_mis++;
            end
          end
        end
        PH_OVER:   if (start && !m_start_prev) new_round();
        PH_PAUSED: if (p_rise) m_ph = PH_PLAY;
        default:   m_ph = PH_IDLE;
      endcase
      m_start_prev = start;
`ifdef PAUSE_EN
      m_pause_prev = pause;
`endif
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("state",      o_state,      (m_ph == PH_PAUSED) ? 1 : m_ph);
    chk("play_en",    o_play_en,    m_ph == PH_PLAY);
    chk("spawn_req",  o_spawn_req,  m_spawn);
    chk("stay_ticks", o_stay_ticks, m_stay());
    chk("level",      o_level,      m_level());
    chk("score",      o_score,      (m_hits > 255) ? 255 : m_hits);
    chk("misses",     o_misses,     (m_mis > 255) ? 255 : m_mis);
    chk("time_left",  o_time_left,  m_tl);
    chk("game_over",  o_game_over,  m_ph == PH_OVER);
`ifdef PAUSE_EN
    chk("paused",     o_paused,     m_ph == PH_PAUSED);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Random ticks; hit/miss only on non-tick cycles. stop_ph < 0 runs max_cyc cycles.
  task automatic run_random(input int max_cyc, input int hit_pct, input int miss_pct,
                            input logic start_lvl, input int stop_ph);
    int n;
    n = 0;
    start = start_lvl;
    while ((stop_ph < 0 || m_ph != stop_ph) && n < max_cyc) begin
      tick = ($urandom_range(0, 1) == 0);
      hit  = !tick && ($urandom_range(0, 99) < hit_pct);
      miss = !tick && ($urandom_range(0, 99) < miss_pct);
      cyc();
      n++;
    end
    tick = 1'b0; hit = 1'b0; miss = 1'b0;
    if (stop_ph >= 0) chk("reach_state", o_state, stop_ph);
  endtask

  initial begin
    // Reset values
    model_reset();
    m_start_prev = 1'b0; m_pause_prev = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_state", o_state, 0);
    chk("rst_time_left", o_time_left, ROUND);
    chk("rst_stay", o_stay_ticks, STY_INIT);

    // IDLE ignores hits and ticks
    run_random(8, 50, 50, 1'b0, -1);

    // Round 1: moderate traffic; hits during COUNTDOWN are ignored
    start = 1'b1; cyc(); start = 1'b0;
    chk("enter_cd", o_state, 1);
    run_random(100, 40, 40, 1'b0, PH_PLAY);
    run_random(3000, 25, 15, 1'b0, PH_OVER);

    // OVER freezes score/misses/level
    run_random(10, 60, 60, 1'b0, -1);

    // Round 2: heavy traffic saturates level, score, misses; start held high into OVER
    start = 1'b1; cyc();
    chk("enter_cd2", o_state, 1);
    run_random(100, 50, 50, 1'b1, PH_PLAY);
    run_random(3000, 100, 100, 1'b1, PH_OVER);
    chk("sat_level", o_level, 7);
    chk("sat_score", o_score, 255);
    chk("sat_stay", o_stay_ticks, 15);
    for (int i = 0; i < 10; i++) cyc();
    chk("held_start_over", o_state, 3);
    start = 1'b0; cyc();
    start = 1'b1; cyc();
    chk("retrigger_cd", o_state, 1);
    start = 1'b0;

    // game_mode drop during PLAY
    run_random(100, 30, 30, 1'b0, PH_PLAY);
    run_random(80, 30, 30, 1'b0, -1);
    gm = 1'b0; cyc();
    chk("gm_idle", o_state, 0);
    chk("gm_score", o_score, 0);
    gm = 1'b1; cyc();

    // Asynchronous reset between clock edges during PLAY
    start = 1'b1; cyc(); start = 1'b0;
    run_random(100, 30, 30, 1'b0, PH_PLAY);
    run_random(60, 40, 20, 1'b0, -1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    m_start_prev = 1'b0; m_pause_prev = 1'b0;
    check_all();
    chk("arst_state", o_state, 0);
    chk("arst_time_left", o_time_left, ROUND);
    chk("arst_stay", o_stay_ticks, STY_INIT);
    chk("arst_score", o_score, 0);
    #1 rst = 1'b0;
    cyc();

`ifdef PAUSE_EN
    begin
      int saved_tl, spawns;
      start = 1'b1; cyc(); start = 1'b0;
      run_random(100, 30, 30, 1'b0, PH_PLAY);
      run_random(90, 30, 30, 1'b0, -1);
      pause = 1'b1; cyc(); pause = 1'b0;
      chk("paused_state", o_state, 1);
      saved_tl = m_tl;
      spawns = 0;
      for (int i = 0; i < 200; i++) begin
        tick = (i % 2 == 0);
        hit  = !tick && ($urandom_range(0, 1) == 0);
        cyc();
        if (o_spawn_req) spawns++;
      end
      tick = 1'b0; hit = 1'b0;
      chk("pause_time_left", o_time_left, saved_tl);
      chk("pause_spawns", spawns, 0);
      pause = 1'b1; cyc(); pause = 1'b0;
      chk("resume_state", o_state, 2);
      run_random(3000, 25, 15, 1'b0, PH_OVER);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mole_round_ctrl.md
Name: mole_round_ctrl

Overview:
Round scheduler for the mole-buster game.
- Sequences a game round: idle, start countdown, timed play, game over.
- Paces mole spawn requests to the mole datapath and configures that datapath's stay time.
- Raises difficulty (level) as hits accumulate and keeps the round score.
- Sits between the clock-divider tick source / keypad and the dot-matrix mole datapath.

Parameters:
- CW, 16: width of all tick counters.
- COUNTDOWN_TICKS, 3: ticks spent in COUNTDOWN.
- ROUND_TICKS, 600: ticks spent in PLAY.
- SPAWN_INIT, 40: initial spawn period in ticks.
- SPAWN_MIN, 8: floor for the spawn period.
- SPAWN_STEP, 4: spawn period decrement per level-up.
- STAY_INIT, 50: initial stay_ticks value.
- STAY_MIN, 10: floor for stay_ticks.
- STAY_STEP, 5: stay_ticks decrement per level-up.
- HITS_PER_LEVEL, 5: hits needed per level-up.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- tick  in  1  one-clk pulse from the divider; the time base for all counters
- game_mode  in  1  1 = mole game selected; 0 forces IDLE
- start  in  1  level/pulse request to begin a round
- hit  in  1  one-clk pulse: mole whacked
- miss  in  1  one-clk pulse: mole expired unhit
- state  out  2  0 = IDLE, 1 = COUNTDOWN, 2 = PLAY, 3 = OVER
- play_en  out  1  high only in PLAY; enables the mole datapath
- spawn_req  out  1  one-clk pulse: datapath spawns a mole
- stay_ticks  out  CW  current mole stay time for the datapath
- level  out  3  difficulty level, 0..7
- score  out  8  hits this round, saturating at 255
- misses  out  8  misses this round, saturating at 255
- time_left  out  CW  remaining PLAY ticks
- game_over  out  1  high in OVER

Behaviour:
Reset (rst=1, async):
- state=IDLE, play_en=0, spawn_req=0, game_over=0.
- stay_ticks=STAY_INIT, level=0, score=0, misses=0, time_left=ROUND_TICKS.
- Internal: spawn period = SPAWN_INIT, hit-in-level counter = 0.

game_mode=0:
- Synchronous return to IDLE with all reset values on the next clk; overrides every state.

State machine (all transitions registered; outputs are registered):
- IDLE:
  - start=1 -> COUNTDOWN.
  - On entry to COUNTDOWN: clear score, misses, level and the hit counter; load stay_ticks=STAY_INIT, spawn period=SPAWN_INIT, countdown=COUNTDOWN_TICKS.
- COUNTDOWN:
  - Decrement the countdown on each tick.
  - The tick at which countdown==1 -> PLAY on the next clk.
  - On entry to PLAY: load time_left=ROUND_TICKS; load the spawn counter to 1 so the first spawn occurs on the first PLAY tick.
- PLAY:
  - Each tick: time_left-1. Spawn counter -1; when it reaches 0, assert spawn_req for exactly one clk in the following cycle and reload the spawn counter with the spawn period.
  - The tick that takes time_left 1->0 -> OVER. No spawn_req is issued on that tick.
- OVER:
  - game_over=1; score, misses and level frozen.
  - start=1 -> COUNTDOWN, with the same clear/load as from IDLE.
  - start held high across OVER->COUNTDOWN does not retrigger; a new round requires start to go low then high (edge-detected internally).

hit / miss handling:
- Counted only in PLAY; ignored in every other state.
- hit and miss in the same clk: both are counted.
- Each hit: score+1 (saturating) and hit counter+1.
- When the hit counter reaches HITS_PER_LEVEL:
  - Clear the hit counter.
  - If level<7: level+1; spawn period = max(SPAWN_MIN, period-SPAWN_STEP); stay_ticks = max(STAY_MIN, stay_ticks-STAY_STEP). The subtraction must not underflow.
  - If level==7: no change beyond clearing the hit counter.
- A new spawn period takes effect at the next reload; the running spawn counter is not altered.

Priority within one clk: rst > game_mode=0 > state transition > hit/miss update.

Latency:
- spawn_req follows its tick by exactly 1 clk.
- state changes 1 clk after the qualifying tick or start.

Optional Feature:
Macro PAUSE_EN.
- Defined:
  - Extra input pause (1 bit) and new state PAUSED, encoded as state=1 with play_en=0; distinguished by an extra output paused (1 bit).
  - pause rising edge in PLAY -> PAUSED: tick ignored; hit/miss ignored; time_left and the spawn counter hold.
  - Next pause rising edge -> PLAY with counters resumed unchanged.
  - game_mode=0 or rst still return to IDLE.
- Not defined: no pause port, no paused port, no PAUSED state.

Test Plan:
1. rst pulse mid-PLAY, asynchronous and between clk edges -> state=0, score=0, time_left=600, stay_ticks=50 immediately.
2. COUNTDOWN_TICKS=3, ROUND_TICKS=20, SPAWN_INIT=5; start -> PLAY after 3 ticks. spawn_req on PLAY ticks 1, 6, 11, 16. OVER after tick 20. Exactly 4 spawn_req pulses.
3. Hit 5 times in PLAY -> level=1, stay_ticks=45, next spawn interval 36. Hit 35 more times -> level=7, stay_ticks=15, period floors at 12. Further hits leave level at 7.
4. hit and miss in the same clk in PLAY -> score+1 and misses+1. Hits during COUNTDOWN/OVER -> no change.
5. game_mode dropped during PLAY -> IDLE next clk. start held high through OVER -> stays OVER until start toggles.
6. PAUSE_EN: pause for 100 ticks mid-PLAY -> time_left unchanged, no spawn_req. Unpause -> spawning resumes with the remaining spawn count.
